hc05_cmd_initiator: RTL and testbench
=====================================

HC05_CMD_INITIATOR -- requirements
Module: hc05_cmd_initiator

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, UART bit rate for 8N1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50_000_000, response wait limit in clocks.
REQ-004 clk_50mhz  input  1  system clock; all logic on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request to send one command frame; sampled each cycle.
REQ-007 cmd_in  input  8  command byte; captured on accepted start.
REQ-008 arg_in  input  8  argument byte; captured on accepted start.
REQ-009 uart_rx  input  1  serial line from the responder's TX; asynchronous to clk_50mhz.
REQ-010 uart_tx  output  1  serial line to the responder's RX; idle high.
REQ-011 busy  output  1  high from the cycle after start is accepted until done pulses.
REQ-012 done  output  1  one-cycle pulse when a transaction ends.
REQ-013 status  output  2  result, valid with done: 00 OK, 01 TIMEOUT, 10 FRAMING_ERR, 11 NACK.
REQ-014 rsp_out  output  8  last response byte received; held until the next response.

Function
REQ-015 Bit period SHALL be BIT_CYCLES = CLOCK_FREQ/BAUD_RATE, integer division (5208 at defaults).
REQ-016 start SHALL be accepted only in IDLE; start while busy SHALL be ignored and have no effect.
REQ-017 Frame SHALL be four 8N1 bytes, LSB first, back to back: 0xA5, cmd, arg, chk = cmd XOR arg.
REQ-018 Each TX byte SHALL be 1 start bit (0), 8 data bits, 1 stop bit (1), each exactly BIT_CYCLES long.
REQ-019 FSM states: IDLE, SEND_SYNC, SEND_CMD, SEND_ARG, SEND_CHK, WAIT_RSP, FINISH.
REQ-020 IDLE->SEND_SYNC on accepted start; SEND_* advance after their stop bit completes; SEND_CHK->WAIT_RSP.
REQ-021 WAIT_RSP->FINISH on first complete RX byte or timeout; FINISH->IDLE after exactly one cycle, done=1 in FINISH.
REQ-022 uart_rx SHALL pass through a 2-flop synchronizer before use.
REQ-023 RX start detected on synchronized 1->0; line re-sampled at BIT_CYCLES/2; if high, treated as glitch and discarded.
REQ-024 RX data bits sampled at mid-bit; stop bit sampled at mid-bit; stop=0 SHALL yield status 10.
REQ-025 RX bytes completing outside WAIT_RSP SHALL be discarded, rsp_out unchanged.
REQ-026 Timeout counter SHALL clear on entry to WAIT_RSP; at TIMEOUT_CYCLES counts with no RX start bit detected, status 01.
REQ-027 Once an RX start bit is detected in WAIT_RSP, the timeout SHALL be suspended until that byte ends.
REQ-028 Valid response byte: rsp_out updated; status 00 if byte equals captured cmd, else 11.
REQ-029 rsp_out SHALL update only on a valid-stop response in WAIT_RSP; a framing error leaves it unchanged.
REQ-030 uart_tx SHALL be high in IDLE, WAIT_RSP, FINISH, and between no bytes of a frame (no idle gap).

Reset
REQ-031 On reset_n low, immediately: state IDLE, uart_tx=1, busy=0, done=0, status=00, rsp_out=0x00, all counters and RX shift logic cleared.
REQ-032 Reset mid-frame SHALL abort the transaction with no done pulse; first accepted start after release begins a fresh frame.

Verification (sim params CLOCK_FREQ=1000, BAUD_RATE=100 -> 10 cycles/bit, TIMEOUT_CYCLES=200)
REQ-033 start with cmd=0x31, arg=0x0F -> uart_tx carries 0xA5,0x31,0x0F,0x3E, 400 cycles total, busy high throughout.
REQ-034 Responder model sends 0x31 after frame -> done pulse, status=00, rsp_out=0x31, busy low next cycle.
REQ-035 Responder sends 0x15 -> status=11, rsp_out=0x15; responder sends 0x31 with stop bit 0 -> status=10, rsp_out unchanged.
REQ-036 No response -> done exactly 200 cycles after WAIT_RSP entry, status=01; 4-cycle low glitch on uart_rx during wait ignored.
REQ-037 start re-asserted every cycle while busy -> exactly one frame sent; reset_n low during SEND_ARG -> uart_tx=1, busy=0, no done.

Source files
------------

// File: rtl/hc05_cmd_initiator.sv
// HC-05 style command initiator: sends a 4-byte 8N1 frame (A5, cmd, arg, chk)
// and waits for a one-byte reply, reporting OK/TIMEOUT/FRAMING/NACK.
module hc05_cmd_initiator #(
  parameter int CLOCK_FREQ     = 50_000_000,
  parameter int BAUD_RATE      = 9600,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk_50mhz,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] cmd_in,
  input  logic [7:0] arg_in,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       busy,
  output logic       done,
  output logic [1:0] status,
  output logic [7:0] rsp_out
);

  localparam int BIT_CYCLES  = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int BW = $clog2(BIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BW-1:0] BIT_LAST  = BW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(HALF_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_TOUT  = 2'b01;
  localparam logic [1:0] ST_FRAME = 2'b10;
  localparam logic [1:0] ST_NACK  = 2'b11;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    SEND_SYNC,
    SEND_CMD,
    SEND_ARG,
    SEND_CHK,
    WAIT_RSP,
    FINISH
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  state_e          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      arg_q, arg_d;
  logic [BW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [1:0]      status_q, status_d;
  logic [7:0]      rsp_q, rsp_d;

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [BW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;

  logic            sending;
  logic            tx_last;
  logic [7:0]      tx_byte;
  logic            tx_line;
  logic            rx_done;
  logic            rx_stop_ok;
  logic            rx_active;

  assign sending = state_q inside {SEND_SYNC, SEND_CMD, SEND_ARG, SEND_CHK};
  assign tx_last = (tx_cnt_q == BIT_LAST) && (tx_bit_q == 4'd9);

  // Timeout pauses only once a start bit has been confirmed at mid-bit.
  assign rx_active = rx_state_q inside {RX_DATA, RX_STOP};

  always_comb begin
    tx_byte = SYNC_BYTE;
    unique case (state_q)
      SEND_CMD: tx_byte = cmd_q;
      SEND_ARG: tx_byte = arg_q;
      SEND_CHK: tx_byte = cmd_q ^ arg_q;
      default:  tx_byte = SYNC_BYTE;
    endcase
  end

  always_comb begin
    tx_line = 1'b1;
    if (sending) begin
      if (tx_bit_q == 4'd0) begin
        tx_line = 1'b0;
      end else if (tx_bit_q <= 4'd8) begin
        tx_line = tx_byte[tx_bit_q[2:0] - 3'd1];
      end
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    rx_stop_ok = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + BW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + BW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_done    = 1'b1;
          rx_stop_ok = rx_sync_q;
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + BW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    arg_d    = arg_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    to_cnt_d = to_cnt_q;
    status_d = status_q;
    rsp_d    = rsp_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SEND_SYNC;
          cmd_d    = cmd_in;
          arg_d    = arg_in;
          tx_cnt_d = '0;
          tx_bit_d = '0;
        end
      end
      SEND_SYNC, SEND_CMD, SEND_ARG, SEND_CHK: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          tx_bit_d = (tx_bit_q == 4'd9) ? 4'd0 : tx_bit_q + 4'd1;
        end else begin
          tx_cnt_d = tx_cnt_q + BW'(1);
        end
        if (tx_last) begin
          unique case (state_q)
            SEND_SYNC: state_d = SEND_CMD;
            SEND_CMD:  state_d = SEND_ARG;
            SEND_ARG:  state_d = SEND_CHK;
            default: begin
              state_d  = WAIT_RSP;
              to_cnt_d = '0;
            end
          endcase
        end
      end
      WAIT_RSP: begin
        if (rx_done) begin
          state_d = FINISH;
          if (!rx_stop_ok) begin
            status_d = ST_FRAME;
          end else begin
            rsp_d    = rx_shift_q;
            status_d = (rx_shift_q == cmd_q) ? ST_OK : ST_NACK;
          end
        end else if (!rx_active) begin
          if (to_cnt_q == TO_LAST) begin
            state_d  = FINISH;
            status_d = ST_TOUT;
          end else begin
            to_cnt_d = to_cnt_q + TW'(1);
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      arg_q      <= '0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      to_cnt_q   <= '0;
      status_q   <= ST_OK;
      rsp_q      <= '0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      arg_q      <= arg_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      to_cnt_q   <= to_cnt_d;
      status_q   <= status_d;
      rsp_q      <= rsp_d;
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  assign uart_tx = tx_line;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == FINISH);
  assign status  = status_q;
  assign rsp_out = rsp_q;

endmodule

// File: tb/tb_hc05_cmd_initiator.sv
// Directed bench for hc05_cmd_initiator at 10 clocks/bit, 200-clock timeout.
// Expected frames and statuses are hand-computed constants.
module tb_hc05_cmd_initiator;

  logic       clk_50mhz = 1'b0;
  logic       reset_n   = 1'b0;
  logic       start     = 1'b0;
  logic [7:0] cmd_in    = 8'h00;
  logic [7:0] arg_in    = 8'h00;
  logic       uart_rx   = 1'b1;
  logic       uart_tx;
  logic       busy;
  logic       done;
  logic [1:0] status;
  logic [7:0] rsp_out;

  int n_cmp = 0;
  int n_err = 0;

  hc05_cmd_initiator #(
    .CLOCK_FREQ(1000),
    .BAUD_RATE(100),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .clk_50mhz(clk_50mhz),
    .reset_n(reset_n),
    .start(start),
    .cmd_in(cmd_in),
    .arg_in(arg_in),
    .uart_rx(uart_rx),
    .uart_tx(uart_tx),
    .busy(busy),
    .done(done),
    .status(status),
    .rsp_out(rsp_out)
  );

  always #5 clk_50mhz = ~clk_50mhz;

  task automatic chk_eq(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                            input logic hold,
                            input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp_b [4];
    logic [7:0] got_b [4];
    logic       eb;
    int         bad, nbusy, k, j;
    exp_b = '{e0, e1, e2, e3};
    got_b = '{8'h00, 8'h00, 8'h00, 8'h00};
    bad   = 0;
    nbusy = 0;
    @(negedge clk_50mhz);
    start  = 1'b1;
    cmd_in = c;
    arg_in = a;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_50mhz);
      if (!hold) start = 1'b0;
      if (i == 50) begin
        cmd_in = ~c;
        arg_in = ~a;
      end
      k = i / 100;
      j = (i % 100) / 10;
      if (j == 0) eb = 1'b0;
      else if (j == 9) eb = 1'b1;
      else eb = exp_b[k][j-1];
      if (uart_tx !== eb) bad++;
      if (busy !== 1'b1) nbusy++;
      if ((i % 10) == 5 && j >= 1 && j <= 8) got_b[k][j-1] = uart_tx;
    end
    start = 1'b0;
    for (int b = 0; b < 4; b++)
      chk_eq($sformatf("tx_byte%0d", b), 32'(got_b[b]), 32'(exp_b[b]));
    chk_eq("tx_bit_timing", bad, 0);
    chk_eq("busy_in_frame", nbusy, 0);
  endtask

  // mode 0: line idle except a 4-cycle low glitch; mode 1: send byte b.
  task automatic drive_rx(input int mode, input logic [7:0] b,
                          input logic stopb, output int lat);
    int idx;
    lat = -1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk_50mhz);
      if (done) begin
        lat = t;
        break;
      end
      if (mode == 0) begin
        uart_rx = !(t >= 50 && t <= 53);
      end else begin
        idx = t / 10;
        if (idx == 0) uart_rx = 1'b0;
        else if (idx <= 8) uart_rx = b[idx-1];
        else if (idx <= 10) uart_rx = stopb;
        else uart_rx = 1'b1;
      end
    end
    uart_rx = 1'b1;
  endtask

  task automatic check_end(input string tag, input int lat,
                           input logic [1:0] st, input logic [7:0] rsp);
    chk_eq({tag, "_done_seen"}, 32'(lat >= 0), 1);
    chk_eq({tag, "_status"}, 32'(status), 32'(st));
    chk_eq({tag, "_rsp"}, 32'(rsp_out), 32'(rsp));
    @(negedge clk_50mhz);
    chk_eq({tag, "_done_1cyc"}, 32'(done), 0);
    chk_eq({tag, "_busy_after"}, 32'(busy), 0);
  endtask

  initial begin
    int lat, ndone, ntx;

    repeat (3) @(negedge clk_50mhz);
    reset_n = 1'b1;
    @(negedge clk_50mhz);
    chk_eq("rst_tx", 32'(uart_tx), 1);
    chk_eq("rst_busy", 32'(busy), 0);
    chk_eq("rst_done", 32'(done), 0);
    chk_eq("rst_status", 32'(status), 0);
    chk_eq("rst_rsp", 32'(rsp_out), 0);

    send_frame(8'h31, 8'h0F, 1'b0, 8'hA5, 8'h31, 8'h0F, 8'h3E);
    drive_rx(1, 8'h31, 1'b1, lat);
    check_end("ok", lat, 2'b00, 8'h31);

    send_frame(8'h31, 8'h0F, 1'b0, 8'hA5, 8'h31, 8'h0F, 8'h3E);
    drive_rx(1, 8'h15, 1'b1, lat);
    check_end("nack", lat, 2'b11, 8'h15);

    send_frame(8'h31, 8'h0F, 1'b0, 8'hA5, 8'h31, 8'h0F, 8'h3E);
    drive_rx(1, 8'h31, 1'b0, lat);
    check_end("frame", lat, 2'b10, 8'h15);

    drive_rx(1, 8'h77, 1'b1, lat);
    chk_eq("idle_rx_no_done", lat, -1);
    chk_eq("idle_rx_rsp", 32'(rsp_out), 32'h15);
    chk_eq("idle_rx_busy", 32'(busy), 0);

    send_frame(8'h5A, 8'hC3, 1'b0, 8'hA5, 8'h5A, 8'hC3, 8'h99);
    drive_rx(0, 8'h00, 1'b1, lat);
    chk_eq("tout_latency", lat, 200);
    check_end("tout", lat, 2'b01, 8'h15);

    send_frame(8'h00, 8'hFF, 1'b1, 8'hA5, 8'h00, 8'hFF, 8'hFF);
    drive_rx(1, 8'h00, 1'b1, lat);
    check_end("hold", lat, 2'b00, 8'h00);
    ntx = 0;
    repeat (60) begin
      @(negedge clk_50mhz);
      if (uart_tx !== 1'b1 || busy !== 1'b0) ntx++;
    end
    chk_eq("hold_single_frame", ntx, 0);

    @(negedge clk_50mhz);
    start  = 1'b1;
    cmd_in = 8'h31;
    arg_in = 8'h0F;
    @(negedge clk_50mhz);
    start = 1'b0;
    repeat (249) @(negedge clk_50mhz);
    reset_n = 1'b0;
    #1;
    chk_eq("abort_tx", 32'(uart_tx), 1);
    chk_eq("abort_busy", 32'(busy), 0);
    chk_eq("abort_done", 32'(done), 0);
    chk_eq("abort_rsp", 32'(rsp_out), 0);
    chk_eq("abort_status", 32'(status), 0);
    repeat (3) @(negedge clk_50mhz);
    reset_n = 1'b1;
    ndone = 0;
    ntx   = 0;
    repeat (500) begin
      @(negedge clk_50mhz);
      if (done !== 1'b0) ndone++;
      if (uart_tx !== 1'b1) ntx++;
    end
    chk_eq("abort_no_done", ndone, 0);
    chk_eq("abort_tx_idle", ntx, 0);

    send_frame(8'h31, 8'h0F, 1'b0, 8'hA5, 8'h31, 8'h0F, 8'h3E);
    drive_rx(1, 8'h31, 1'b1, lat);
    check_end("fresh", lat, 2'b00, 8'h31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
